// File: rtl/ec_point_add_dbl_seq.sv
// Affine EC point add/double sequencer driving external modular divider and multiplier engines.
// Optional ECPA_CONST_TIME_EN: trivial cases still run a full engine sequence on dummy operands.
module ec_point_add_dbl_seq #(
  parameter int WIDTH = 256,
  parameter int CYC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_add,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  output logic             o_busy,
  output logic             o_finish,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic             o_inf,
  output logic [CYC_W-1:0] o_cycles,
  output logic             o_div_req,
  output logic [WIDTH-1:0] o_div_num,
  output logic [WIDTH-1:0] o_div_den,
  input  logic             i_div_done,
  input  logic [WIDTH-1:0] i_div_res,
  output logic             o_mul_req,
  output logic [WIDTH-1:0] o_mul_a,
  output logic [WIDTH-1:0] o_mul_b,
  input  logic             i_mul_done,
  input  logic [WIDTH-1:0] i_mul_res,
  output logic [3:0]       o_state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CLASS = 4'd1;
  localparam logic [3:0] S_SQX   = 4'd2;
  localparam logic [3:0] S_NUMD  = 4'd3;
  localparam logic [3:0] S_DIVW  = 4'd4;
  localparam logic [3:0] S_LSQ   = 4'd5;
  localparam logic [3:0] S_X3    = 4'd6;
  localparam logic [3:0] S_TSUB  = 4'd7;
  localparam logic [3:0] S_MULY  = 4'd8;
  localparam logic [3:0] S_Y3    = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  localparam logic [1:0] SEL_SUM = 2'd0;
  localparam logic [1:0] SEL_P1  = 2'd1;
  localparam logic [1:0] SEL_P2  = 2'd2;
  localparam logic [1:0] SEL_INF = 2'd3;

  localparam logic [CYC_W-1:0] CNT_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] u, v, p);
    logic [WIDTH:0] d;
    d = {1'b0, u} - {1'b0, v};
    if (u < v) d = d + {1'b0, p};
    return d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_3s_a(input logic [WIDTH-1:0] s, a, p);
    logic [WIDTH+2:0] t;
    t = {3'b000, s} + {2'b00, s, 1'b0} + {3'b000, a};
    for (int k = 0; k < 3; k++) begin
      if (t >= {3'b000, p}) t = t - {3'b000, p};
    end
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_dbl(input logic [WIDTH-1:0] y, p);
    logic [WIDTH:0] t;
    t = {y, 1'b0};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_inc(input logic [WIDTH-1:0] x, p);
    logic [WIDTH:0] t;
    t = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
    if (t >= {1'b0, p}) t = '0;
    return t[WIDTH-1:0];
  endfunction

  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] p_q, a_q, x1_q, y1_q, x2_q, y2_q;
  logic             add_q;
  logic [WIDTH-1:0] wx1_q, wy1_q, wx2_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] lam_q, mres_q, x3_q;
  logic [CYC_W-1:0] cnt_q, cycles_q;
  logic             div_req_q, mul_req_q;
  logic [WIDTH-1:0] div_num_q, div_den_q, mul_a_q, mul_b_q;
  logic [WIDTH-1:0] ox_q, oy_q;
  logic             oinf_q;

  // Point classification, evaluated from the operands latched at start.
  logic             p1_inf, p2_inf, same_x, geo_sum, run_seq, real_ops, dbl_c;
  logic [1:0]       sel_c, sel_cur;
  logic [WIDTH-1:0] cw1x, cw1y, cw2x, cw2y, x3_c, y3_c, t_c;
  logic             mul_done_ok, div_done_ok;

  assign p1_inf  = (&x1_q) && (&y1_q);
  assign p2_inf  = (&x2_q) && (&y2_q);
  assign same_x  = (x1_q == x2_q);
  assign geo_sum = !p1_inf && !p2_inf && !(same_x && ((y1_q != y2_q) || (y1_q == '0)));

  always_comb begin
    sel_c = SEL_SUM;
    if (!add_q)        sel_c = SEL_P1;
    else if (p1_inf)   sel_c = SEL_P2;
    else if (p2_inf)   sel_c = SEL_P1;
    else if (!geo_sum) sel_c = SEL_INF;
  end

`ifdef ECPA_CONST_TIME_EN
  assign run_seq  = 1'b1;
  assign real_ops = geo_sum;
`else
  assign run_seq  = (sel_c == SEL_SUM);
  assign real_ops = 1'b1;
`endif

  // Dummy operands keep x2 != x1 so the divider never sees a zero denominator.
  assign cw1x  = (real_ops || !p1_inf) ? x1_q : '0;
  assign cw1y  = (real_ops || !p1_inf) ? y1_q : '0;
  assign cw2x  = real_ops ? x2_q : mod_inc(cw1x, p_q);
  assign cw2y  = real_ops ? y2_q : cw1y;
  assign dbl_c = real_ops && same_x;

  assign x3_c    = mod_sub(mod_sub(mres_q, wx1_q, p_q), wx2_q, p_q);
  assign t_c     = mod_sub(wx1_q, x3_q, p_q);
  assign y3_c    = mod_sub(mres_q, wy1_q, p_q);
  assign sel_cur = (state_q == S_CLASS) ? sel_c : sel_q;

  // Engine handshake: *_req is a one-cycle pulse on entry to a wait state with operands
  // stable until the matching *_done; a done pulse outside that wait state is dropped.
  assign mul_done_ok = i_mul_done && !mul_req_q;
  assign div_done_ok = i_div_done && !div_req_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_CLASS;
      S_CLASS: begin
        if (!run_seq)   state_d = S_DONE;
        else if (dbl_c) state_d = S_SQX;
        else            state_d = S_DIVW;
      end
      S_SQX:   if (mul_done_ok) state_d = S_NUMD;
      S_NUMD:  state_d = S_DIVW;
      S_DIVW:  if (div_done_ok) state_d = S_LSQ;
      S_LSQ:   if (mul_done_ok) state_d = S_X3;
      S_X3:    state_d = S_TSUB;
      S_TSUB:  state_d = S_MULY;
      S_MULY:  if (mul_done_ok) state_d = S_Y3;
      S_Y3:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      p_q <= '0; a_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
      add_q     <= 1'b0;
      wx1_q <= '0; wy1_q <= '0; wx2_q <= '0;
      sel_q     <= SEL_SUM;
      lam_q <= '0; mres_q <= '0; x3_q <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      div_req_q <= 1'b0;
      mul_req_q <= 1'b0;
      div_num_q <= '0; div_den_q <= '0; mul_a_q <= '0; mul_b_q <= '0;
      ox_q <= '0; oy_q <= '0; oinf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_req_q <= (state_d == S_DIVW) && (state_q != S_DIVW);
      mul_req_q <= (state_d != state_q) &&
                   ((state_d == S_SQX) || (state_d == S_LSQ) || (state_d == S_MULY));
      if ((state_q != S_IDLE) && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_ONE;

      case (state_q)
        S_IDLE: if (i_start) begin
          p_q <= i_p; a_q <= i_a;
          x1_q <= i_x1; y1_q <= i_y1; x2_q <= i_x2; y2_q <= i_y2;
          add_q <= i_add;
          cnt_q <= CNT_ONE;
        end
        S_CLASS: begin
          wx1_q     <= cw1x;
          wy1_q     <= cw1y;
          wx2_q     <= cw2x;
          sel_q     <= sel_c;
          div_num_q <= mod_sub(cw2y, cw1y, p_q);
          div_den_q <= mod_sub(cw2x, cw1x, p_q);
          mul_a_q   <= cw1x;
          mul_b_q   <= cw1x;
        end
        S_SQX:  if (mul_done_ok) mres_q <= i_mul_res;
        S_NUMD: begin
          div_num_q <= mod_3s_a(mres_q, a_q, p_q);
          div_den_q <= mod_dbl(wy1_q, p_q);
        end
        S_DIVW: if (div_done_ok) begin
          lam_q   <= i_div_res;
          mul_a_q <= i_div_res;
          mul_b_q <= i_div_res;
        end
        S_LSQ:  if (mul_done_ok) mres_q <= i_mul_res;
        S_X3:   x3_q <= x3_c;
        S_TSUB: begin
          mul_a_q <= lam_q;
          mul_b_q <= t_c;
        end
        S_MULY: if (mul_done_ok) mres_q <= i_mul_res;
        default: ;
      endcase

      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        cycles_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        case (sel_cur)
          SEL_P1:  begin ox_q <= x1_q; oy_q <= y1_q; oinf_q <= p1_inf; end
          SEL_P2:  begin ox_q <= x2_q; oy_q <= y2_q; oinf_q <= p2_inf; end
          SEL_INF: begin ox_q <= '1;   oy_q <= '1;   oinf_q <= 1'b1;   end
          default: begin ox_q <= x3_q; oy_q <= y3_c; oinf_q <= 1'b0;   end
        endcase
      end
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_finish  = (state_q == S_DONE);
  assign o_x       = ox_q;
  assign o_y       = oy_q;
  assign o_inf     = oinf_q;
  assign o_cycles  = cycles_q;
  assign o_div_req = div_req_q;
  assign o_div_num = div_num_q;
  assign o_div_den = div_den_q;
  assign o_mul_req = mul_req_q;
  assign o_mul_a   = mul_a_q;
  assign o_mul_b   = mul_b_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_ec_point_add_dbl_seq.sv
// Bench for ec_point_add_dbl_seq on the curve y^2 = x^3 + 2x + b mod 17 with latency-3 engines.
module tb_ec_point_add_dbl_seq;
  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int LAT = 3;
  localparam logic [W-1:0] P_MOD = 8'd17;
  localparam logic [W-1:0] A_CO  = 8'd2;
  localparam logic [W-1:0] INF   = 8'hFF;
`ifdef ECPA_CONST_TIME_EN
  localparam int TM = 2;
  localparam int TD = 1;
`else
  localparam int TM = 0;
  localparam int TD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_add;
  logic [W-1:0]  i_x1, i_y1, i_x2, i_y2;
  logic          o_busy, o_finish, o_inf;
  logic [W-1:0]  o_x, o_y;
  logic [CW-1:0] o_cycles;
  logic          o_div_req, i_div_done, o_mul_req, i_mul_done;
  logic [W-1:0]  o_div_num, o_div_den, i_div_res, o_mul_a, o_mul_b, i_mul_res;
  logic [3:0]    o_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mul_reqs = 0;
  int div_reqs = 0;
  int fin_count = 0;
  logic [W-1:0] last_num, last_den;
  logic [2*W:0] exp_q[$];

  always #5 clk = ~clk;

  ec_point_add_dbl_seq #(.WIDTH(W), .CYC_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_add(i_add),
    .i_p(P_MOD), .i_a(A_CO), .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2),
    .o_busy(o_busy), .o_finish(o_finish), .o_x(o_x), .o_y(o_y), .o_inf(o_inf),
    .o_cycles(o_cycles),
    .o_div_req(o_div_req), .o_div_num(o_div_num), .o_div_den(o_div_den),
    .i_div_done(i_div_done), .i_div_res(i_div_res),
    .o_mul_req(o_mul_req), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_done(i_mul_done), .i_mul_res(i_mul_res),
    .o_state(o_state)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int inv17(input int d);
    for (int k = 1; k < 17; k++) if (((d * k) % 17) == 1) return k;
    return 0;
  endfunction

  // Behavioural multiplier: done pulse LAT cycles after the request cycle.
  initial begin
    int left;
    int res;
    left = 0; res = 0;
    i_mul_done = 1'b0; i_mul_res = '0;
    forever begin
      @(posedge clk); #1;
      i_mul_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin i_mul_done = 1'b1; i_mul_res = 8'(res); end
      end
      if (o_mul_req) begin
        mul_reqs++;
        res  = (int'(o_mul_a) * int'(o_mul_b)) % 17;
        left = LAT;
      end
    end
  end

  // Behavioural divider: num * den^-1 mod 17.
  initial begin
    int left;
    int res;
    left = 0; res = 0;
    i_div_done = 1'b0; i_div_res = '0;
    forever begin
      @(posedge clk); #1;
      i_div_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin i_div_done = 1'b1; i_div_res = 8'(res); end
      end
      if (o_div_req) begin
        div_reqs++;
        last_num = o_div_num;
        last_den = o_div_den;
        checks++;
        if (o_div_den == '0) begin
          errors++;
          $display("FAIL div_den_nonzero got=%0d need nonzero", o_div_den);
        end
        res  = (int'(o_div_num) * inv17(int'(o_div_den))) % 17;
        left = LAT;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_finish) begin
        fin_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_finish got x=%0d y=%0d inf=%0b need none", o_x, o_y, o_inf);
        end else begin
          e = exp_q.pop_front();
          if ({o_inf, o_x, o_y} !== e) begin
            errors++;
            $display("FAIL result got inf=%0b x=%0d y=%0d need inf=%0b x=%0d y=%0d",
                     o_inf, o_x, o_y, e[2*W], e[2*W-1:W], e[W-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  task automatic run_op(input logic [W-1:0] x1, y1, x2, y2, input logic add,
                        input logic [W-1:0] ex, ey, input logic einf,
                        input int emul, edv, input logic trivial,
                        input int enum_v, eden_v, input logic poke);
    int st, fin, m0, d0, f0;
    bit seen;
    m0 = mul_reqs; d0 = div_reqs; f0 = fin_count;
    @(posedge clk); #1;
    i_x1 = x1; i_y1 = y1; i_x2 = x2; i_y2 = y2; i_add = add; i_start = 1'b1;
    exp_q.push_back({einf, ex, ey});
    st = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    seen = 0; fin = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (poke && k == 3) begin
        i_x1 = 8'd5; i_y1 = 8'd1; i_x2 = 8'd5; i_y2 = 8'd1; i_add = 1'b1; i_start = 1'b1;
      end
      if (poke && k == 4) i_start = 1'b0;
      if (o_finish) begin seen = 1; fin = cyc; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL finish_timeout got=none need=o_finish within 200 cycles");
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
`ifndef ECPA_CONST_TIME_EN
    if (trivial) check("trivial_latency", fin - st, 2);
`endif
    check("o_cycles", int'(o_cycles), fin - st);
    check("mul_reqs", mul_reqs - m0, emul);
    check("div_reqs", div_reqs - d0, edv);
    check("finish_pulses", fin_count - f0, 1);
    check("busy_after", int'(o_busy), 0);
    if (enum_v >= 0) begin
      check("div_num", int'(last_num), enum_v);
      check("div_den", int'(last_den), eden_v);
    end
  endtask

  initial begin
    int m0;
    bit bad;
    rst = 1'b1; i_start = 1'b0; i_add = 1'b0;
    i_x1 = '0; i_y1 = '0; i_x2 = '0; i_y2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          int'({o_busy, o_finish, o_inf, o_div_req, o_mul_req, o_state, o_x, o_y, o_cycles}), 0);
    check("reset_operands", int'({o_div_num, o_div_den, o_mul_a, o_mul_b}), 0);

    // doubling (5,1) -> (6,3): lambda = 9/2 = 13
    run_op(8'd5, 8'd1, 8'd5, 8'd1, 1'b1, 8'd6, 8'd3, 1'b0, 3, 1, 1'b0, 9, 2, 1'b0);
    // add (5,1)+(6,3) -> (10,6)
    run_op(8'd5, 8'd1, 8'd6, 8'd3, 1'b1, 8'd10, 8'd6, 1'b0, 2, 1, 1'b0, 2, 1, 1'b0);
    // P + (-P) -> infinity
    run_op(8'd5, 8'd1, 8'd5, 8'd16, 1'b1, INF, INF, 1'b1, TM, TD, 1'b1, -1, -1, 1'b0);
    // inf + P2 -> P2
    run_op(INF, INF, 8'd6, 8'd3, 1'b1, 8'd6, 8'd3, 1'b0, TM, TD, 1'b1, -1, -1, 1'b0);
    // P1 + inf -> P1
    run_op(8'd10, 8'd6, INF, INF, 1'b1, 8'd10, 8'd6, 1'b0, TM, TD, 1'b1, -1, -1, 1'b0);
    // add=0 selects P1
    run_op(8'd6, 8'd3, 8'd10, 8'd6, 1'b0, 8'd6, 8'd3, 1'b0, TM, TD, 1'b1, -1, -1, 1'b0);
    // doubling a point with y=0 -> infinity
    run_op(8'd3, 8'd0, 8'd3, 8'd0, 1'b1, INF, INF, 1'b1, TM, TD, 1'b1, -1, -1, 1'b0);
    // start and input changes while busy are ignored
    run_op(8'd5, 8'd1, 8'd6, 8'd3, 1'b1, 8'd10, 8'd6, 1'b0, 2, 1, 1'b0, 2, 1, 1'b1);

    // reset during DIVW, divider done then arrives while idle
    m0 = mul_reqs;
    @(posedge clk); #1;
    i_x1 = 8'd5; i_y1 = 8'd1; i_x2 = 8'd6; i_y2 = 8'd3; i_add = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    bad = 1;
    for (int k = 0; k < 20 && bad; k++) begin
      @(negedge clk);
      if (o_div_req) bad = 0;
    end
    check("abort_saw_div_req", int'(bad), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_busy || o_finish || o_state != 4'd0) bad = 1;
    end
    check("abort_stays_idle", int'(bad), 0);
    check("abort_outputs_zero", int'({o_inf, o_x, o_y, o_cycles}), 0);
    check("abort_no_mul", mul_reqs - m0, 0);

    // recovers normally after the abort
    run_op(8'd5, 8'd1, 8'd5, 8'd1, 1'b1, 8'd6, 8'd3, 1'b0, 3, 1, 1'b0, 9, 2, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
